// File: rtl/cpu_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_watchdog.sv
// Down-counting watchdog for an outstanding memory access; used only when ARB_TIMEOUT_EN is defined.
// expire_o is asserted in the CYC-th consecutive enabled cycle after a clear.
module arb_watchdog #(
    parameter int unsigned CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CW'(CYC - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= CW'(CYC - 1);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-ported memory between instruction fetch and data access.
// Define ARB_TIMEOUT_EN to abort accesses whose mem_ack_i never arrives (adds err_o).
//
// state   | meaning
// IDLE    | no access outstanding; arbitrate pending requests
// BUSY_IF | fetch outstanding on the memory port
// BUSY_DM | load/store outstanding on the memory port
// RESP    | ready pulse to the granted requester; requests not sampled
module mem_port_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
`ifdef ARB_TIMEOUT_EN
   ,output logic              err_o
`endif
);

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              done;
    logic              unused_addr_lsb;

    // Memory is word-addressed; byte offsets are dropped.
    assign unused_addr_lsb = ^{if_addr_i[1:0], dm_addr_i[1:0]};

`ifdef ARB_TIMEOUT_EN
    logic err_q, err_d;
    logic busy;
    logic wd_expire;

    assign busy = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_DM);

    arb_watchdog #(
        .CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (!busy),
        .en_i     (busy),
        .expire_o (wd_expire)
    );
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_ready_d   = 1'b0;
        dm_ready_d   = 1'b0;
        done         = 1'b0;
`ifdef ARB_TIMEOUT_EN
        err_d        = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // On contention the requester not served last wins.
                if (dm_req_i && (!if_req_i || (last_grant_q == GNT_IF))) begin
                    last_grant_d = GNT_DM;
                    mem_req_d    = 1'b1;
                    mem_we_d     = dm_we_i;
                    mem_addr_d   = {dm_addr_i[ADDR_W-1:2], 2'b00};
                    mem_wdata_d  = dm_wdata_i;
                    state_d      = ST_BUSY_DM;
                end else if (if_req_i) begin
                    last_grant_d = GNT_IF;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = {if_addr_i[ADDR_W-1:2], 2'b00};
                    state_d      = ST_BUSY_IF;
                end
            end
            ST_BUSY_IF, ST_BUSY_DM: begin
                if (mem_ack_i) begin
                    done = 1'b1;
                    if (!mem_we_q) begin
                        if (state_q == ST_BUSY_DM) begin
                            dm_rdata_d = mem_rdata_i;
                        end else begin
                            if_rdata_d = mem_rdata_i;
                        end
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_expire) begin
                    done  = 1'b1;
                    err_d = 1'b1;
                    if (!mem_we_q) begin
                        if (state_q == ST_BUSY_DM) begin
                            dm_rdata_d = DATA_W'(TIMEOUT_DATA);
                        end else begin
                            if_rdata_d = DATA_W'(TIMEOUT_DATA);
                        end
                    end
                end
`endif
                if (done) begin
                    mem_req_d  = 1'b0;
                    state_d    = ST_RESP;
                    if_ready_d = (state_q == ST_BUSY_IF);
                    dm_ready_d = (state_q == ST_BUSY_DM);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_IF;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ready_q   <= 1'b0;
            dm_ready_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ready_q   <= if_ready_d;
            dm_ready_q   <= dm_ready_d;
`ifdef ARB_TIMEOUT_EN
            err_q        <= err_d;
`endif
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign dm_ready_o  = dm_ready_q;
    assign stall_o     = (if_req_i & ~if_ready_q) | (dm_req_i & ~dm_ready_q);
`ifdef ARB_TIMEOUT_EN
    assign err_o       = err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers push expected responses,
// a negedge monitor pops them on ready pulses, a memory model answers with random latency.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO_CYC = 8;
`else
    localparam int unsigned TO_CYC = 255;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        dm_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        stall_o;
`ifdef ARB_TIMEOUT_EN
    logic        err_o;
`endif

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ready_o  (if_ready_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ready_o  (dm_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o)
`ifdef ARB_TIMEOUT_EN
       ,.err_o       (err_o)
`endif
    );

    typedef struct {
        logic [31:0] data;
        bit          to;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        if_q[$];
    exp_t        dm_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] dm_last = '0;
    int          lat_mode = -1;   // >=0 fixed, -1 random, -2 never ack
    bit          late_ack_req = 1'b0;
    bit          err_exp = 1'b0;
    int          cyc = 0;
    bit          smp_if = 1'b0;
    bit          smp_dm = 1'b0;
    bit          last_dm = 1'b0;
    int          start_cyc_q[$];
    bit          start_dm_q[$];
    logic [31:0] last_mem_addr = '0;
    int          last_drop_len = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : mem_init(a);
    endfunction

    initial forever #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc++;
        smp_if = if_req_i;
        smp_dm = dm_req_i;
    end

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Memory model: checks each new access against the round-robin rule, then acks.
    initial begin
        bit          tx_act = 1'b0;
        bit          exp_dm;
        int          tx_cnt = 0;
        int          tx_len = 0;
        logic [31:0] tx_addr = '0;
        logic [31:0] tx_wdata = '0;
        logic        tx_we = 1'b0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (!rst_i) begin
                tx_act  = 1'b0;
                last_dm = 1'b0;
                continue;
            end
            if (late_ack_req) begin
                late_ack_req = 1'b0;
                mem_ack_i    = 1'b1;
                mem_rdata_i  = 32'h5555_AAAA;
                continue;
            end
            if (tx_act && !mem_req_o) begin
`ifdef ARB_TIMEOUT_EN
                last_drop_len = tx_len;
`else
                check("mem_req_held_until_ack", mem_req_o, 1'b1);
`endif
                tx_act = 1'b0;
            end
            if (!tx_act && mem_req_o) begin
                exp_dm = smp_dm && (!smp_if || !last_dm);
                check("grant_has_request", smp_if || smp_dm, 1'b1);
                last_dm = exp_dm;
                start_cyc_q.push_back(cyc);
                start_dm_q.push_back(exp_dm);
                check("mem_addr", mem_addr_o,
                      exp_dm ? {dm_addr_i[31:2], 2'b00} : {if_addr_i[31:2], 2'b00});
                check("mem_we", mem_we_o, exp_dm ? dm_we_i : 1'b0);
                if (exp_dm && dm_we_i) check("mem_wdata", mem_wdata_o, dm_wdata_i);
                tx_addr       = mem_addr_o;
                tx_we         = mem_we_o;
                tx_wdata      = mem_wdata_o;
                last_mem_addr = mem_addr_o;
                tx_act        = 1'b1;
                tx_len        = 0;
                if (lat_mode >= 0)       tx_cnt = lat_mode;
                else if (lat_mode == -1) tx_cnt = int'($urandom_range(0, 4));
                else                     tx_cnt = 1 << 30;
            end
            if (tx_act) begin
                tx_len++;
                if (tx_len > 1) begin
                    check("mem_addr_stable", mem_addr_o, tx_addr);
                    check("mem_we_stable", mem_we_o, tx_we);
                    check("mem_wdata_stable", mem_wdata_o, tx_wdata);
                end
                if (tx_cnt == 0) begin
                    mem_ack_i = 1'b1;
                    if (tx_we) begin
                        phys_mem[tx_addr] = tx_wdata;
                        mem_rdata_i       = $urandom;
                    end else begin
                        mem_rdata_i = phys_rd(tx_addr);
                    end
                    tx_act = 1'b0;
                end else begin
                    tx_cnt--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every ready pulse.
    initial begin
        bit   p_if = 1'b0;
        bit   p_dm = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                p_if = 1'b0;
                p_dm = 1'b0;
                continue;
            end
            check("stall", stall_o, (if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o));
            if (if_ready_o) begin
                check("if_ready_single_pulse", p_if, 1'b0);
                check("if_ready_expected", if_q.size() != 0, 1'b1);
                if (if_q.size() != 0) begin
                    e = if_q.pop_front();
                    check("if_rdata", if_rdata_o, e.data);
                end
            end
            if (dm_ready_o) begin
                check("dm_ready_single_pulse", p_dm, 1'b0);
                check("dm_ready_expected", dm_q.size() != 0, 1'b1);
                if (dm_q.size() != 0) begin
                    e = dm_q.pop_front();
                    if (e.to) err_exp = 1'b1;
                    check("dm_rdata", dm_rdata_o, e.data);
                end
            end
`ifdef ARB_TIMEOUT_EN
            check("err", err_o, err_exp);
`endif
            p_if = if_ready_o;
            p_dm = dm_ready_o;
        end
    end

    task automatic do_if(input logic [31:0] addr, input int budget);
        exp_t e;
        bit   seen = 1'b0;
        int   n = 0;
        @(posedge clk_i);
        #1;
        if_addr_i = addr;
        e.data    = ref_rd({addr[31:2], 2'b00});
        e.to      = 1'b0;
        if_q.push_back(e);
        if_req_i = 1'b1;
        while (!seen && n < budget) begin
            @(negedge clk_i);
            n++;
            seen = if_ready_o;
        end
        check("if_done", seen, 1'b1);
        @(posedge clk_i);
        #1;
        if_req_i = 1'b0;
    endtask

    task automatic do_dm(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int budget, input bit expect_done, input bit to);
        exp_t        e;
        bit          seen = 1'b0;
        int          n = 0;
        logic [31:0] a;
        @(posedge clk_i);
        #1;
        a          = {addr[31:2], 2'b00};
        dm_addr_i  = addr;
        dm_we_i    = we;
        dm_wdata_i = wdata;
        if (expect_done) begin
            if (to) begin
                if (!we) dm_last = 32'hDEAD_BEEF;
            end else if (we) begin
                ref_mem[a] = wdata;
            end else begin
                dm_last = ref_rd(a);
            end
            e.data = dm_last;
            e.to   = to;
            dm_q.push_back(e);
        end
        dm_req_i = 1'b1;
        while (!seen && n < budget) begin
            @(negedge clk_i);
            n++;
            seen = dm_ready_o;
        end
        check("dm_done", seen, expect_done);
        if (seen) begin
            @(posedge clk_i);
            #1;
            dm_req_i = 1'b0;
        end
    endtask

    task automatic pair_check(input string name);
        int n0;
        n0 = start_cyc_q.size();
        fork
            do_if(32'($urandom_range(0, 255)), 30);
            do_dm(1'b0, 32'h100 + 32'($urandom_range(0, 255)), $urandom, 30, 1'b1, 1'b0);
        join
        check({name, "_count"}, start_cyc_q.size() - n0, 2);
        if (start_cyc_q.size() >= n0 + 2) begin
            check({name, "_first_dm"}, start_dm_q[n0], 1'b1);
            check({name, "_second_if"}, start_dm_q[n0 + 1], 1'b0);
            check({name, "_gap"}, start_cyc_q[n0 + 1] - start_cyc_q[n0], 3);
        end
    endtask

    initial begin
        phys_mem[32'h4] = 32'h2002_0005;
        ref_mem[32'h4]  = 32'h2002_0005;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, 32'h0);
        check("rst_rdata", if_rdata_o | dm_rdata_o, 32'h0);
        check("rst_ctrl", {mem_req_o, mem_we_o, if_ready_o, dm_ready_o, stall_o}, 32'h0);

        // Single fetch, ack one cycle after mem_req_o.
        lat_mode = 1;
        do_if(32'h0000_0006, 20);
        check("t1_mem_addr", last_mem_addr, 32'h0000_0004);
        check("t1_if_rdata", if_rdata_o, 32'h2002_0005);
        @(negedge clk_i);
        check("t1_stall_after", stall_o, 1'b0);

        // Simultaneous requests: DM first, IF right after RESP.
        lat_mode = 0;
        for (int i = 0; i < 4; i++) pair_check($sformatf("pair%0d", i));

        // Store with a slow ack; read back through fetch port.
        lat_mode = 5;
        do_dm(1'b1, 32'h0000_0010, 32'hCAFE_0001, 30, 1'b1, 1'b0);
        check("t3_mem_we", mem_we_o, 1'b1);
        check("t3_dm_rdata_kept", dm_rdata_o, dm_last);
        lat_mode = -1;
        do_if(32'h0000_0012, 20);

        // Random concurrent traffic.
        fork
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk_i);
                    do_if(32'($urandom_range(0, 255)), 40);
                end
            end
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk_i);
                    do_dm(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 255)),
                          $urandom, 40, 1'b1, 1'b0);
                end
            end
        join

        // Memory never acks.
        lat_mode = -2;
`ifdef ARB_TIMEOUT_EN
        do_dm(1'b0, 32'h0000_01F0, 32'h1357_9BDF, 40, 1'b1, 1'b1);
        check("to_drop_len", last_drop_len, TO_CYC);
        check("to_dm_rdata", dm_rdata_o, 32'hDEAD_BEEF);
        repeat (5) @(negedge clk_i);
        check("to_err_sticky", err_o, 1'b1);
        do_dm(1'b1, 32'h0000_01F4, 32'hA5A5_0F0F, 4, 1'b0, 1'b0);
`else
        do_dm(1'b0, 32'h0000_01F0, 32'h1357_9BDF, 1000, 1'b0, 1'b0);
        check("noack_stall_high", stall_o, 1'b1);
`endif
        check("busy_before_rst", mem_req_o, 1'b1);

        // Asynchronous reset in the middle of BUSY_DM.
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_mem_req", mem_req_o, 1'b0);
        check("arst_mem_we", mem_we_o, 1'b0);
        check("arst_mem_addr", mem_addr_o, 32'h0);
        check("arst_mem_wdata", mem_wdata_o, 32'h0);
        check("arst_if_rdata", if_rdata_o, 32'h0);
        check("arst_dm_rdata", dm_rdata_o, 32'h0);
        check("arst_ready", {if_ready_o, dm_ready_o}, 32'h0);
`ifdef ARB_TIMEOUT_EN
        check("arst_err", err_o, 1'b0);
`endif
        dm_req_i = 1'b0;
        if_req_i = 1'b0;
        err_exp  = 1'b0;
        dm_last  = '0;
        if_q.delete();
        dm_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i        = 1'b1;
        late_ack_req = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            check("late_ack_ignored_req", mem_req_o, 1'b0);
            check("late_ack_ignored_rdata", dm_rdata_o, 32'h0);
        end

        // Arbiter must be back in IDLE with last grant = IF.
        lat_mode = 0;
        pair_check("post_rst_pair");
        lat_mode = -1;
        do_dm(1'b0, 32'h0000_0104, 32'h0, 20, 1'b1, 1'b0);

        repeat (3) @(negedge clk_i);
        check("if_q_drained", if_q.size(), 0);
        check("dm_q_drained", dm_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
